// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between ALU (A) and load/store (B) writebacks.
// Latency: 1 cycle from accepted request to rf_wr_*/fwd_*; one write per cycle sustained.
// Backpressure: a_ready/b_ready drop on wb_stall, own valid low, or losing arbitration; requester holds.
module rf_wb_arbiter #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int FIXED_PRI = 0,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   input  logic              wb_stall,
   output logic              rf_wr_en,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic              fwd_valid,
   output logic [ADDR_W-1:0] fwd_addr,
   output logic [DATA_W-1:0] fwd_data,
   output logic [CNT_W-1:0]  conflict_cnt
);

   // One writeback request: destination register plus the value to write.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_req_t;

   // Round-robin pointer: which requester was granted most recently.
   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_e;

   src_e    last_gnt_q;
   src_e    last_gnt_d;
   logic    gnt_a;
   logic    gnt_b;
   logic    gnt_any;
   logic    conflict;
   wb_req_t sel_req;

   logic             wr_en_q;
   wb_req_t          wr_q;
   logic [CNT_W-1:0] cnt_q;

   // Pick at most one requester; a tie goes to B under fixed priority, else to whoever did not win last.
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (!wb_stall) begin
         if (a_valid && b_valid) begin
            if (FIXED_PRI != 0) begin
               gnt_b = 1'b1;
            end else if (last_gnt_q == SRC_A) begin
               gnt_b = 1'b1;
            end else begin
               gnt_a = 1'b1;
            end
         end else begin
            gnt_a = a_valid;
            gnt_b = b_valid;
         end
      end
   end

   assign gnt_any  = gnt_a | gnt_b;
   assign conflict = a_valid & b_valid & ~wb_stall;
   assign a_ready  = gnt_a;
   assign b_ready  = gnt_b;

   // Pointer follows every grant and holds on idle or stalled cycles.
   always_comb begin
      last_gnt_d = last_gnt_q;
      if (gnt_a) begin
         last_gnt_d = SRC_A;
      end else if (gnt_b) begin
         last_gnt_d = SRC_B;
      end
   end

   // Pointer register; reset to A so that B wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt_q <= SRC_A;
      end else begin
         last_gnt_q <= last_gnt_d;
      end
   end

   // Route the granted request toward the output stage.
   always_comb begin
      sel_req = '0;
      if (gnt_b) begin
         sel_req.addr = b_addr;
         sel_req.data = b_data;
      end else begin
         sel_req.addr = a_addr;
         sel_req.data = a_data;
      end
   end

   // Output stage: a grant is staged for exactly one cycle; writes to x0 are staged but never enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_q <= 1'b0;
         wr_q    <= '0;
      end else if (gnt_any) begin
         wr_en_q <= (sel_req.addr != '0);
         wr_q    <= sel_req;
      end else begin
         wr_en_q <= 1'b0;
      end
   end

   // Saturating count of cycles in which both requesters competed outside a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign rf_wr_en     = wr_en_q;
   assign rf_wr_addr   = wr_q.addr;
   assign rf_wr_data   = wr_q.data;
   assign fwd_valid    = wr_en_q;
   assign fwd_addr     = wr_q.addr;
   assign fwd_data     = wr_q.data;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed checks of arbitration, staging, x0 handling, stall and counter saturation.
// Three instances share one stimulus: round-robin, fixed-priority, and a 2-bit counter variant.
// Inputs change 1 ns after posedge; outputs are sampled on negedge.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_valid, b_valid, wb_stall;
   logic [4:0]  a_addr, b_addr;
   logic [31:0] a_data, b_data;

   logic        rr_a_ready, rr_b_ready, rr_wr_en, rr_fwd_valid;
   logic [4:0]  rr_wr_addr, rr_fwd_addr;
   logic [31:0] rr_wr_data, rr_fwd_data;
   logic [15:0] rr_cnt;

   logic        fp_a_ready, fp_b_ready, fp_wr_en, fp_fwd_valid;
   logic [4:0]  fp_wr_addr, fp_fwd_addr;
   logic [31:0] fp_wr_data, fp_fwd_data;
   logic [15:0] fp_cnt;

   logic        sat_a_ready, sat_b_ready, sat_wr_en, sat_fwd_valid;
   logic [4:0]  sat_wr_addr, sat_fwd_addr;
   logic [31:0] sat_wr_data, sat_fwd_data;
   logic [1:0]  sat_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRI(0), .CNT_W(16)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(rr_a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(rr_b_ready),
      .wb_stall(wb_stall),
      .rf_wr_en(rr_wr_en), .rf_wr_addr(rr_wr_addr), .rf_wr_data(rr_wr_data),
      .fwd_valid(rr_fwd_valid), .fwd_addr(rr_fwd_addr), .fwd_data(rr_fwd_data),
      .conflict_cnt(rr_cnt)
   );

   rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRI(1), .CNT_W(16)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(fp_a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(fp_b_ready),
      .wb_stall(wb_stall),
      .rf_wr_en(fp_wr_en), .rf_wr_addr(fp_wr_addr), .rf_wr_data(fp_wr_data),
      .fwd_valid(fp_fwd_valid), .fwd_addr(fp_fwd_addr), .fwd_data(fp_fwd_data),
      .conflict_cnt(fp_cnt)
   );

   rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRI(0), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(sat_a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(sat_b_ready),
      .wb_stall(wb_stall),
      .rf_wr_en(sat_wr_en), .rf_wr_addr(sat_wr_addr), .rf_wr_data(sat_wr_data),
      .fwd_valid(sat_fwd_valid), .fwd_addr(sat_fwd_addr), .fwd_data(sat_fwd_data),
      .conflict_cnt(sat_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Step to just after the next rising edge, where inputs are changed.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        exp3_b [4];
      logic        exp4_b [3];
      logic [4:0]  prev_addr;
      logic [31:0] prev_data;
      int          a_idx;
      int          b_idx;

      exp3_b = '{1'b1, 1'b0, 1'b1, 1'b0};
      exp4_b = '{1'b1, 1'b0, 1'b1};

      rst_n    = 1'b0;
      a_valid  = 1'b0; a_addr = '0; a_data = '0;
      b_valid  = 1'b0; b_addr = '0; b_data = '0;
      wb_stall = 1'b0;

      // Reset state.
      repeat (2) step();
      check("rst_wr_en",     64'(rr_wr_en), 64'd0);
      check("rst_wr_addr",   64'(rr_wr_addr), 64'd0);
      check("rst_wr_data",   64'(rr_wr_data), 64'd0);
      check("rst_fwd_valid", 64'(rr_fwd_valid), 64'd0);
      check("rst_cnt",       64'(rr_cnt), 64'd0);
      rst_n = 1'b1;

      // A only: accepted same cycle, written next cycle, gone the cycle after.
      step();
      a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
      @(negedge clk);
      check("a_only_a_ready", 64'(rr_a_ready), 64'd1);
      check("a_only_b_ready", 64'(rr_b_ready), 64'd0);
      step();
      a_valid = 1'b0;
      @(negedge clk);
      check("a_only_wr_en",    64'(rr_wr_en), 64'd1);
      check("a_only_wr_addr",  64'(rr_wr_addr), 64'd5);
      check("a_only_wr_data",  64'(rr_wr_data), 64'hDEADBEEF);
      check("a_only_fwd_vld",  64'(rr_fwd_valid), 64'd1);
      check("a_only_fwd_addr", 64'(rr_fwd_addr), 64'd5);
      check("a_only_fwd_data", 64'(rr_fwd_data), 64'hDEADBEEF);
      step();
      @(negedge clk);
      check("a_only_en_drop",   64'(rr_wr_en), 64'd0);
      check("a_only_fwd_drop",  64'(rr_fwd_valid), 64'd0);
      check("a_only_addr_hold", 64'(rr_wr_addr), 64'd5);

      // Round-robin tie: last grant was A, so order is B,A,B,A.
      a_idx = 0; b_idx = 0;
      prev_addr = '0; prev_data = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA000 + 32'(a_idx);
         b_valid = 1'b1; b_addr = 5'd2; b_data = 32'hB000 + 32'(b_idx);
         @(negedge clk);
         if (i > 0) begin
            check("rr_wr_en",   64'(rr_wr_en), 64'd1);
            check("rr_wr_addr", 64'(rr_wr_addr), 64'(prev_addr));
            check("rr_wr_data", 64'(rr_wr_data), 64'(prev_data));
         end
         check("rr_b_ready", 64'(rr_b_ready), 64'(exp3_b[i]));
         check("rr_a_ready", 64'(rr_a_ready), 64'(!exp3_b[i]));
         if (exp3_b[i]) begin
            prev_addr = 5'd2; prev_data = 32'hB000 + 32'(b_idx); b_idx++;
         end else begin
            prev_addr = 5'd1; prev_data = 32'hA000 + 32'(a_idx); a_idx++;
         end
      end
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);
      check("rr_last_addr", 64'(rr_wr_addr), 64'd1);
      check("rr_last_data", 64'(rr_wr_data), 64'hA001);
      check("rr_cnt_4",     64'(rr_cnt), 64'd4);
      check("sat_cnt_4",    64'(sat_cnt), 64'd3);

      // Fixed priority: B wins every tie; round-robin instance alternates B,A,B.
      for (int i = 0; i < 3; i++) begin
         step();
         a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA100;
         b_valid = 1'b1; b_addr = 5'd2; b_data = 32'hB100;
         @(negedge clk);
         check("fp_a_ready", 64'(fp_a_ready), 64'd0);
         check("fp_b_ready", 64'(fp_b_ready), 64'd1);
         check("rr4_b_ready", 64'(rr_b_ready), 64'(exp4_b[i]));
         if (i > 0) begin
            check("fp_wr_addr", 64'(fp_wr_addr), 64'd2);
         end
      end
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);
      check("fp_last_en",   64'(fp_wr_en), 64'd1);
      check("fp_last_addr", 64'(fp_wr_addr), 64'd2);
      check("fp_last_data", 64'(fp_wr_data), 64'hB100);
      check("rr_cnt_7",     64'(rr_cnt), 64'd7);

      // x0 write: accepted but never enabled toward the register file.
      step();
      b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h1234;
      @(negedge clk);
      check("x0_b_ready", 64'(rr_b_ready), 64'd1);
      step();
      b_valid = 1'b0;
      @(negedge clk);
      check("x0_wr_en",    64'(rr_wr_en), 64'd0);
      check("x0_fwd_vld",  64'(rr_fwd_valid), 64'd0);
      check("x0_wr_addr",  64'(rr_wr_addr), 64'd0);
      check("x0_wr_data",  64'(rr_wr_data), 64'h1234);

      // Stall with both valid: no grants, no counting, pointer untouched (last grant was B).
      for (int i = 0; i < 2; i++) begin
         step();
         wb_stall = 1'b1;
         a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hA200;
         b_valid = 1'b1; b_addr = 5'd4; b_data = 32'hB200;
         @(negedge clk);
         check("stall_a_ready", 64'(rr_a_ready), 64'd0);
         check("stall_b_ready", 64'(rr_b_ready), 64'd0);
      end
      step();
      wb_stall = 1'b0;
      @(negedge clk);
      check("stall_wr_en",  64'(rr_wr_en), 64'd0);
      check("stall_cnt",    64'(rr_cnt), 64'd7);
      check("post_stall_a", 64'(rr_a_ready), 64'd1);
      check("post_stall_b", 64'(rr_b_ready), 64'd0);
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);
      check("post_stall_addr", 64'(rr_wr_addr), 64'd3);
      check("rr_cnt_8",        64'(rr_cnt), 64'd8);
      check("sat_cnt_hold",    64'(sat_cnt), 64'd3);

      // Reset mid-cycle while a write is staged.
      step();
      a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
      step();
      a_valid = 1'b0;
      check("pre_rst_en", 64'(rr_wr_en), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_en",   64'(rr_wr_en), 64'd0);
      check("mid_rst_fwd",  64'(rr_fwd_valid), 64'd0);
      check("mid_rst_addr", 64'(rr_wr_addr), 64'd0);
      check("mid_rst_cnt",  64'(rr_cnt), 64'd0);
      check("mid_rst_sat",  64'(sat_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // After reset the pointer is A again, so B takes the first tie.
      step();
      a_valid = 1'b1; a_addr = 5'd9;  a_data = 32'h99;
      b_valid = 1'b1; b_addr = 5'd10; b_data = 32'hAA;
      @(negedge clk);
      check("rst_tie_b_ready", 64'(rr_b_ready), 64'd1);
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);
      check("rst_tie_addr", 64'(rr_wr_addr), 64'd10);
      check("rst_tie_data", 64'(rr_wr_data), 64'hAA);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
